// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve, data-memory req/ack access, MEM/WB register; 1-cycle ALU latency, >=2-cycle ld/st.
// Stalls upstream until dmem_ack; optional ack watchdog under DMEM_TIMEOUT_EN.
module mem_stage_ctrl #(
   parameter logic [5:0] NOOP_OP        = 6'b111111,
   parameter int         TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_rd,
   input  logic [2:0]  i_m,
   input  logic [1:0]  i_wb,
   input  logic [31:0] i_target,
   input  logic        i_eq,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_valB,
   input  logic [5:0]  i_operation,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        o_stall,
   output logic        o_pc_src,
   output logic [31:0] o_branch_target,
   output logic [4:0]  o_rd,
   output logic [1:0]  o_wb,
   output logic [31:0] o_read_data,
   output logic [31:0] o_alu_result,
   output logic [5:0]  o_operation,
   output logic        o_mem_err
);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic w_valid;
   logic w_mem_op;
   logic w_capture;
   logic w_retire;
   logic w_abort;
   logic w_tmo_hit;

   // Transaction hold registers; addr/wdata/we double as the dmem request fields.
   logic [4:0]  r_hold_rd;
   logic [1:0]  r_hold_wb;
   logic [5:0]  r_hold_op;
   logic [31:0] r_hold_alu;
   logic [31:0] r_hold_valb;
   logic        r_hold_we;
   logic        r_req;

   logic [4:0]  r_rd;
   logic [1:0]  r_wb;
   logic [31:0] r_read_data;
   logic [31:0] r_alu_result;
   logic [5:0]  r_operation;

   assign w_valid  = (i_operation != NOOP_OP);
   assign w_mem_op = w_valid & (i_m[1] | i_m[2]);

`ifdef DMEM_TIMEOUT_EN
   logic [7:0] r_tcnt;
   logic       r_mem_err;

   assign w_tmo_hit = (r_tcnt == 8'(TIMEOUT_CYCLES - 1));

   // Counter sits at zero while idle, so it starts from zero on every ACCESS entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tcnt    <= 8'd0;
         r_mem_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE)
            r_tcnt <= 8'd0;
         else if (!dmem_ack)
            r_tcnt <= r_tcnt + 8'd1;
         if (w_abort)
            r_mem_err <= 1'b1;
      end
   end

   assign o_mem_err = r_mem_err;
`else
   logic [7:0] w_unused_tmo;

   assign w_unused_tmo = 8'(TIMEOUT_CYCLES);
   assign w_tmo_hit    = 1'b0;
   assign o_mem_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_retire     = 1'b0;
      w_abort      = 1'b0;
      o_stall      = 1'b0;
      o_pc_src     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_pc_src = w_valid & i_m[0] & i_eq;
            if (w_mem_op) begin
               o_stall      = 1'b1;
               w_capture    = 1'b1;
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // Ack takes priority over a watchdog expiry in the same cycle.
            if (dmem_ack) begin
               w_retire     = 1'b1;
               w_next_state = S_IDLE;
            end else if (w_tmo_hit) begin
               w_abort      = 1'b1;
               w_next_state = S_IDLE;
            end else begin
               o_stall = 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_rd    <= 5'd0;
         r_hold_wb    <= 2'd0;
         r_hold_op    <= 6'd0;
         r_hold_alu   <= 32'd0;
         r_hold_valb  <= 32'd0;
         r_hold_we    <= 1'b0;
         r_req        <= 1'b0;
         r_rd         <= 5'd0;
         r_wb         <= 2'd0;
         r_read_data  <= 32'd0;
         r_alu_result <= 32'd0;
         r_operation  <= NOOP_OP;
      end else if (r_state == S_IDLE) begin
         if (w_capture) begin
            r_hold_rd   <= i_rd;
            r_hold_wb   <= i_wb;
            r_hold_op   <= i_operation;
            r_hold_alu  <= i_alu_result;
            r_hold_valb <= i_valB;
            r_hold_we   <= i_m[2];
            r_req       <= 1'b1;
            r_wb        <= 2'd0;
            r_operation <= NOOP_OP;
         end else begin
            r_rd         <= i_rd;
            r_wb         <= i_wb;
            r_read_data  <= 32'd0;
            r_alu_result <= i_alu_result;
            r_operation  <= i_operation;
         end
      end else begin
         if (w_retire) begin
            r_rd         <= r_hold_rd;
            r_wb         <= r_hold_wb;
            r_alu_result <= r_hold_alu;
            r_operation  <= r_hold_op;
            r_read_data  <= r_hold_we ? 32'd0 : dmem_rdata;
            r_req        <= 1'b0;
         end else begin
            r_wb        <= 2'd0;
            r_operation <= NOOP_OP;
            if (w_abort)
               r_req <= 1'b0;
         end
      end
   end

   assign dmem_req        = r_req;
   assign dmem_we         = r_hold_we;
   assign dmem_addr       = r_hold_alu;
   assign dmem_wdata      = r_hold_valb;
   assign o_branch_target = i_target;
   assign o_rd            = r_rd;
   assign o_wb            = r_wb;
   assign o_read_data     = r_read_data;
   assign o_alu_result    = r_alu_result;
   assign o_operation     = r_operation;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl; the watchdog section runs when DMEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  i_rd;
   logic [2:0]  i_m;
   logic [1:0]  i_wb;
   logic [31:0] i_target;
   logic        i_eq;
   logic [31:0] i_alu_result;
   logic [31:0] i_valB;
   logic [5:0]  i_operation;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        o_stall;
   logic        o_pc_src;
   logic [31:0] o_branch_target;
   logic [4:0]  o_rd;
   logic [1:0]  o_wb;
   logic [31:0] o_read_data;
   logic [31:0] o_alu_result;
   logic [5:0]  o_operation;
   logic        o_mem_err;

   int n_vec = 0;
   int n_err = 0;

   mem_stage_ctrl #(
      .NOOP_OP        (6'b111111),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_rd            (i_rd),
      .i_m             (i_m),
      .i_wb            (i_wb),
      .i_target        (i_target),
      .i_eq            (i_eq),
      .i_alu_result    (i_alu_result),
      .i_valB          (i_valB),
      .i_operation     (i_operation),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_addr       (dmem_addr),
      .dmem_wdata      (dmem_wdata),
      .dmem_rdata      (dmem_rdata),
      .dmem_ack        (dmem_ack),
      .o_stall         (o_stall),
      .o_pc_src        (o_pc_src),
      .o_branch_target (o_branch_target),
      .o_rd            (o_rd),
      .o_wb            (o_wb),
      .o_read_data     (o_read_data),
      .o_alu_result    (o_alu_result),
      .o_operation     (o_operation),
      .o_mem_err       (o_mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_in();
      i_operation  = 6'b111111;
      i_m          = 3'b000;
      i_wb         = 2'b00;
      i_rd         = 5'd0;
      i_eq         = 1'b0;
      i_target     = 32'd0;
      i_alu_result = 32'd0;
      i_valB       = 32'd0;
   endtask

   task automatic set_op(input logic [5:0] op, input logic [2:0] m, input logic [1:0] wb,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] valb);
      i_operation  = op;
      i_m          = m;
      i_wb         = wb;
      i_rd         = rd;
      i_alu_result = alu;
      i_valB       = valb;
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      idle_in();
      step();
      step();
      chk("rst_op",    32'(o_operation), 32'h3F);
      chk("rst_wb",    32'(o_wb),        32'h0);
      chk("rst_rd",    32'(o_rd),        32'h0);
      chk("rst_req",   32'(dmem_req),    32'h0);
      chk("rst_stall", 32'(o_stall),     32'h0);
      chk("rst_err",   32'(o_mem_err),   32'h0);
      rst = 1'b0;

      // ALU op retires after one edge
      set_op(6'h20, 3'b000, 2'b01, 5'd5, 32'h1234, 32'h0);
      mid();
      chk("alu_stall", 32'(o_stall), 32'h0);
      step();
      chk("alu_rd",  32'(o_rd),         32'h5);
      chk("alu_res", o_alu_result,      32'h1234);
      chk("alu_wb",  32'(o_wb),         32'h1);
      chk("alu_op",  32'(o_operation),  32'h20);
      chk("alu_rdata", o_read_data,     32'h0);

      // Load, ack arrives in the fourth ACCESS cycle
      set_op(6'h23, 3'b010, 2'b11, 5'd7, 32'h40, 32'h99);
      mid();
      chk("ld_stall_c0", 32'(o_stall), 32'h1);
      chk("ld_req_c0",   32'(dmem_req), 32'h0);
      step();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            dmem_ack   = 1'b1;
            dmem_rdata = 32'hDEADBEEF;
         end
         mid();
         chk("ld_stall", 32'(o_stall),     (i == 3) ? 32'h0 : 32'h1);
         chk("ld_req",   32'(dmem_req),    32'h1);
         chk("ld_addr",  dmem_addr,        32'h40);
         chk("ld_we",    32'(dmem_we),     32'h0);
         chk("ld_bub_wb", 32'(o_wb),       32'h0);
         chk("ld_bub_op", 32'(o_operation), 32'h3F);
         chk("ld_bub_rd", 32'(o_rd),       32'h5);
         step();
      end
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      chk("ld_rdata", o_read_data,       32'hDEADBEEF);
      chk("ld_wb",    32'(o_wb),         32'h3);
      chk("ld_rd",    32'(o_rd),         32'h7);
      chk("ld_alu",   o_alu_result,      32'h40);
      chk("ld_op",    32'(o_operation),  32'h23);
      chk("ld_req_done", 32'(dmem_req),  32'h0);

      // Store with immediate ack directly behind the load
      set_op(6'h2B, 3'b100, 2'b00, 5'd0, 32'h80, 32'hA5A5A5A5);
      mid();
      chk("st_stall_c0", 32'(o_stall), 32'h1);
      step();
      chk("st_bub_rdata", o_read_data, 32'hDEADBEEF);
      chk("st_bub_op", 32'(o_operation), 32'h3F);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h12345678;
      idle_in();
      mid();
      chk("st_stall_a1", 32'(o_stall), 32'h0);
      chk("st_req",   32'(dmem_req), 32'h1);
      chk("st_we",    32'(dmem_we),  32'h1);
      chk("st_wdata", dmem_wdata,    32'hA5A5A5A5);
      chk("st_addr",  dmem_addr,     32'h80);
      step();
      dmem_ack = 1'b0;
      chk("st_rdata", o_read_data,      32'h0);
      chk("st_op",    32'(o_operation), 32'h2B);
      chk("st_req_done", 32'(dmem_req), 32'h0);

      // Both mem bits set behaves as a store
      set_op(6'h2B, 3'b110, 2'b00, 5'd0, 32'h84, 32'h5A);
      step();
      dmem_ack = 1'b1;
      idle_in();
      mid();
      chk("rw_we", 32'(dmem_we), 32'h1);
      step();
      dmem_ack = 1'b0;

      // Ack while idle is ignored
      set_op(6'h20, 3'b000, 2'b01, 5'd9, 32'h77, 32'h0);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF;
      mid();
      chk("iack_stall", 32'(o_stall), 32'h0);
      step();
      dmem_ack = 1'b0;
      idle_in();
      chk("iack_req",   32'(dmem_req),    32'h0);
      chk("iack_op",    32'(o_operation), 32'h20);
      chk("iack_rd",    32'(o_rd),        32'h9);
      chk("iack_rdata", o_read_data,      32'h0);
      mid();
      chk("iack_stall2", 32'(o_stall), 32'h0);

      // Branch resolution
      set_op(6'h04, 3'b001, 2'b00, 5'd0, 32'h0, 32'h0);
      i_eq     = 1'b1;
      i_target = 32'h100;
      mid();
      chk("br_taken",  32'(o_pc_src), 32'h1);
      chk("br_target", o_branch_target, 32'h100);
      step();
      i_eq = 1'b0;
      mid();
      chk("br_ne", 32'(o_pc_src), 32'h0);
      step();
      i_eq        = 1'b1;
      i_operation = 6'b111111;
      mid();
      chk("br_noop", 32'(o_pc_src), 32'h0);
      step();

      // Branch presented while a load is in flight
      set_op(6'h23, 3'b010, 2'b11, 5'd2, 32'h44, 32'h0);
      i_eq = 1'b0;
      step();
      set_op(6'h04, 3'b001, 2'b00, 5'd0, 32'h0, 32'h0);
      i_eq       = 1'b1;
      i_target   = 32'h200;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hCAFE;
      mid();
      chk("br_acc",     32'(o_pc_src), 32'h0);
      chk("br_acc_tgt", o_branch_target, 32'h200);
      step();
      dmem_ack = 1'b0;
      idle_in();
      chk("br_acc_op",    32'(o_operation), 32'h23);
      chk("br_acc_rdata", o_read_data,      32'hCAFE);

`ifdef DMEM_TIMEOUT_EN
      // Watchdog abort after four ACCESS cycles without ack
      set_op(6'h23, 3'b010, 2'b11, 5'd3, 32'h48, 32'h0);
      mid();
      chk("to_stall_c0", 32'(o_stall), 32'h1);
      step();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("to_stall", 32'(o_stall),  (i == 3) ? 32'h0 : 32'h1);
         chk("to_req",   32'(dmem_req), 32'h1);
         step();
      end
      chk("to_req_done", 32'(dmem_req),    32'h0);
      chk("to_err",      32'(o_mem_err),   32'h1);
      chk("to_op",       32'(o_operation), 32'h3F);
      set_op(6'h20, 3'b000, 2'b01, 5'd6, 32'h55, 32'h0);
      mid();
      chk("to_alu_stall", 32'(o_stall), 32'h0);
      step();
      chk("to_alu_op",  32'(o_operation), 32'h20);
      chk("to_alu_rd",  32'(o_rd),        32'h6);
      chk("to_err_held", 32'(o_mem_err),  32'h1);
`else
      chk("no_tmo_err", 32'(o_mem_err), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
